// File: rtl/ball_centroid_tracker.sv
// Ball centroid tracker: per-frame hit accumulation, frame-close snapshot and a
// sequential centroid divide. Define BALL_TRACKER_BBOX_EN to build the bounding box logic.

module ball_centroid_tracker #(
    parameter int H_START    = 144,
    parameter int V_START    = 35,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [12:0] H_CNT,
    input  logic [12:0] V_CNT,
    input  logic        HIT,
    output logic [9:0]  X_POS,
    output logic [9:0]  Y_POS,
    output logic [18:0] PIXELS,
    output logic        FOUND,
    output logic        VALID,
    output logic        OVERRUN,
    output logic [39:0] BBOX,
    output logic [15:0] DEBUG
);

    localparam logic [12:0] H_LO      = 13'(H_START);
    localparam logic [12:0] H_HI      = 13'(H_START + H_ACTIVE);
    localparam logic [12:0] V_LO      = 13'(V_START);
    localparam logic [12:0] V_HI      = 13'(V_START + V_ACTIVE);
    localparam logic [18:0] MIN_CNT   = 19'(MIN_PIXELS);
    localparam logic [4:0]  LAST_ITER = 5'd28;
    localparam logic [9:0]  CMIN_RST  = 10'd1023;
    localparam logic [9:0]  CMAX_RST  = 10'd0;
    localparam logic [39:0] BBOX_RST  = {CMIN_RST, CMAX_RST, CMIN_RST, CMAX_RST};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_REPORT
    } state_t;

    // One restoring-division iteration: returns {remainder, shifted dividend/quotient}.
    function automatic logic [47:0] div_step(input logic [18:0] rem,
                                             input logic [28:0] quo,
                                             input logic [18:0] dvs);
        logic [19:0] trial;
        logic [18:0] rem_n;
        logic        qbit;
        trial = {rem, quo[28]};
        if (trial >= {1'b0, dvs}) begin
            rem_n = 19'(trial - {1'b0, dvs});
            qbit  = 1'b1;
        end else begin
            rem_n = trial[18:0];
            qbit  = 1'b0;
        end
        return {rem_n, quo[27:0], qbit};
    endfunction

    logic [12:0] h_p0_d, h_p0_q;
    logic [12:0] v_p0_d, v_p0_q;
    logic [12:0] v_p1_d, v_p1_q;
    logic        hit_p0_d, hit_p0_q;
    logic        en_p0_d, en_p0_q;

    logic [18:0] cnt_d, cnt_q;
    logic [28:0] sum_x_d, sum_x_q;
    logic [28:0] sum_y_d, sum_y_q;

    state_t      state_d, state_q;
    logic [4:0]  iter_d, iter_q;
    logic [18:0] snap_cnt_d, snap_cnt_q;
    logic [28:0] quo_x_d, quo_x_q;
    logic [28:0] quo_y_d, quo_y_q;
    logic [18:0] rem_x_d, rem_x_q;
    logic [18:0] rem_y_d, rem_y_q;

    logic [9:0]  x_pos_d, x_pos_q;
    logic [9:0]  y_pos_d, y_pos_q;
    logic [18:0] pixels_d, pixels_q;
    logic        found_d, found_q;
    logic        valid_d, valid_q;
    logic        overrun_d, overrun_q;

`ifdef BALL_TRACKER_BBOX_EN
    logic [9:0]  x_min_d, x_min_q;
    logic [9:0]  x_max_d, x_max_q;
    logic [9:0]  y_min_d, y_min_q;
    logic [9:0]  y_max_d, y_max_q;
    logic [39:0] snap_box_d, snap_box_q;
    logic [39:0] bbox_d, bbox_q;
`endif

    logic        active_p0;
    logic        close_p0;
    logic        take_p0;
    logic [9:0]  x_p0;
    logic [9:0]  y_p0;
    logic [47:0] step_x;
    logic [47:0] step_y;

    // Stage p0: registered scan position, mask and enable.
    assign active_p0 = (h_p0_q >= H_LO) && (h_p0_q < H_HI) &&
                       (v_p0_q >= V_LO) && (v_p0_q < V_HI);
    assign close_p0  = (v_p0_q < v_p1_q);
    assign take_p0   = en_p0_q && hit_p0_q && active_p0;
    assign x_p0      = 10'(h_p0_q - H_LO);
    assign y_p0      = 10'(v_p0_q - V_LO);
    assign step_x    = div_step(rem_x_q, quo_x_q, snap_cnt_q);
    assign step_y    = div_step(rem_y_q, quo_y_q, snap_cnt_q);

    always_comb begin
        h_p0_d     = H_CNT;
        v_p0_d     = V_CNT;
        v_p1_d     = v_p0_q;
        hit_p0_d   = HIT;
        en_p0_d    = ENABLE;

        cnt_d      = cnt_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        state_d    = state_q;
        iter_d     = iter_q;
        snap_cnt_d = snap_cnt_q;
        quo_x_d    = quo_x_q;
        quo_y_d    = quo_y_q;
        rem_x_d    = rem_x_q;
        rem_y_d    = rem_y_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        pixels_d   = pixels_q;
        found_d    = found_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;
`ifdef BALL_TRACKER_BBOX_EN
        x_min_d    = x_min_q;
        x_max_d    = x_max_q;
        y_min_d    = y_min_q;
        y_max_d    = y_max_q;
        snap_box_d = snap_box_q;
        bbox_d     = bbox_q;
`endif

        // Stage p1: accumulate. A hit on the close cycle already belongs to the new frame.
        if (!en_p0_q || close_p0) begin
            cnt_d   = '0;
            sum_x_d = '0;
            sum_y_d = '0;
`ifdef BALL_TRACKER_BBOX_EN
            x_min_d = CMIN_RST;
            x_max_d = CMAX_RST;
            y_min_d = CMIN_RST;
            y_max_d = CMAX_RST;
`endif
        end
        if (take_p0) begin
            cnt_d   = cnt_d + 19'd1;
            sum_x_d = sum_x_d + 29'(x_p0);
            sum_y_d = sum_y_d + 29'(y_p0);
`ifdef BALL_TRACKER_BBOX_EN
            if (x_p0 < x_min_d) x_min_d = x_p0;
            if (x_p0 > x_max_d) x_max_d = x_p0;
            if (y_p0 < y_min_d) y_min_d = y_p0;
            if (y_p0 > y_max_d) y_max_d = y_p0;
`endif
        end

        // Stage p2: snapshot, divide and report.
        case (state_q)
            S_IDLE: begin
                if (close_p0 && en_p0_q) begin
                    snap_cnt_d = cnt_q;
                    quo_x_d    = sum_x_q;
                    quo_y_d    = sum_y_q;
                    rem_x_d    = '0;
                    rem_y_d    = '0;
                    iter_d     = '0;
`ifdef BALL_TRACKER_BBOX_EN
                    snap_box_d = {x_min_q, x_max_q, y_min_q, y_max_q};
`endif
                    state_d    = (cnt_q < MIN_CNT) ? S_REPORT : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                {rem_x_d, quo_x_d} = step_x;
                {rem_y_d, quo_y_d} = step_y;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) state_d = S_REPORT;
            end
            S_REPORT: begin
                pixels_d = snap_cnt_q;
                found_d  = (snap_cnt_q >= MIN_CNT);
                // Centroid holds its last good value through frames without a detection.
                if (found_d) begin
                    x_pos_d = quo_x_q[9:0];
                    y_pos_d = quo_y_q[9:0];
                end
`ifdef BALL_TRACKER_BBOX_EN
                bbox_d   = snap_box_q;
`endif
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (close_p0 && en_p0_q && (state_q != S_IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        snap_cnt_q <= snap_cnt_d;
        quo_x_q    <= quo_x_d;
        quo_y_q    <= quo_y_d;
        rem_x_q    <= rem_x_d;
        rem_y_q    <= rem_y_d;
`ifdef BALL_TRACKER_BBOX_EN
        snap_box_q <= snap_box_d;
`endif
        if (RST) begin
            h_p0_q    <= '0;
            v_p0_q    <= '0;
            v_p1_q    <= '0;
            hit_p0_q  <= 1'b0;
            en_p0_q   <= 1'b0;
            cnt_q     <= '0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            state_q   <= S_IDLE;
            iter_q    <= '0;
            x_pos_q   <= '0;
            y_pos_q   <= '0;
            pixels_q  <= '0;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef BALL_TRACKER_BBOX_EN
            x_min_q   <= CMIN_RST;
            x_max_q   <= CMAX_RST;
            y_min_q   <= CMIN_RST;
            y_max_q   <= CMAX_RST;
            bbox_q    <= BBOX_RST;
`endif
        end else begin
            h_p0_q    <= h_p0_d;
            v_p0_q    <= v_p0_d;
            v_p1_q    <= v_p1_d;
            hit_p0_q  <= hit_p0_d;
            en_p0_q   <= en_p0_d;
            cnt_q     <= cnt_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            state_q   <= state_d;
            iter_q    <= iter_d;
            x_pos_q   <= x_pos_d;
            y_pos_q   <= y_pos_d;
            pixels_q  <= pixels_d;
            found_q   <= found_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef BALL_TRACKER_BBOX_EN
            x_min_q   <= x_min_d;
            x_max_q   <= x_max_d;
            y_min_q   <= y_min_d;
            y_max_q   <= y_max_d;
            bbox_q    <= bbox_d;
`endif
        end
    end

    assign X_POS   = x_pos_q;
    assign Y_POS   = y_pos_q;
    assign PIXELS  = pixels_q;
    assign FOUND   = found_q;
    assign VALID   = valid_q;
    assign OVERRUN = overrun_q;
    assign DEBUG   = {x_pos_q[7:0], y_pos_q[7:0]};
`ifdef BALL_TRACKER_BBOX_EN
    assign BBOX    = bbox_q;
`else
    assign BBOX    = BBOX_RST;
`endif

endmodule

// File: doc/ball_centroid_tracker.md
# ball_centroid_tracker

Downstream of the ball detection stage in the VGA pixel pipeline. Consumes the per-pixel ball mask (`HIT`) together with the VGA scan counters and accumulates hit count, coordinate sums and bounding box over each frame. At every frame boundary it snapshots the totals and runs a sequential divider to produce the ball centroid. Results are registered for the Nios II PIO and seven-segment debug, and are later used by the paddle controller.

## Interface
Parameters:
- `H_START`, 144: H_CNT value of the first active column.
- `V_START`, 35: V_CNT value of the first active line.
- `H_ACTIVE`, 640: active width in pixels.
- `V_ACTIVE`, 480: active height in lines.
- `MIN_PIXELS`, 16: minimum hit count per frame for a valid detection.

Ports:
- `CLK` in 1: pixel clock (VGA_CLK domain). One clock; reset is synchronous and active-high.
- `RST` in 1: synchronous, active-high reset.
- `ENABLE` in 1: tracking enable.
- `H_CNT` in 13: VGA horizontal counter.
- `V_CNT` in 13: VGA vertical counter.
- `HIT` in 1: ball mask for the current (H_CNT, V_CNT) pixel.
- `X_POS` out 10: centroid column, 0..639.
- `Y_POS` out 10: centroid line, 0..479.
- `PIXELS` out 19: hit count of the last closed frame.
- `FOUND` out 1: last closed frame had PIXELS ≥ MIN_PIXELS.
- `VALID` out 1: one-cycle pulse when the outputs update.
- `OVERRUN` out 1: sticky; set when a frame closed while the divider was busy.
- `BBOX` out 40: {x_min, x_max, y_min, y_max}, 10 bits each.
- `DEBUG` out 16: {X_POS[7:0], Y_POS[7:0]}, routed to the sevseg display.

## Operation
- Active pixel: H_START ≤ H_CNT < H_START+H_ACTIVE and V_START ≤ V_CNT < V_START+V_ACTIVE.
  - x = H_CNT−H_START.
  - y = V_CNT−V_START.
- Accumulators:
  - cnt: 19 bits.
  - sum_x, sum_y: 29 bits each.
  - xmin/ymin: reset to 1023.
  - xmax/ymax: reset to 0.
- Per cycle, if ENABLE and HIT and the pixel is active:
  - cnt += 1.
  - sum_x += x, sum_y += y.
  - Bounding box min/max updated.
  - Inputs are registered once before accumulation.
- Frame close: the registered V_CNT < its previous registered value (V wrap).
- FSM states:
  - IDLE:
    - On close with ENABLE high, snapshot cnt, sum_x, sum_y and the box.
    - Clear the accumulators in the same cycle. A hit on the close cycle loads into the cleared accumulators; it belongs to the new frame.
    - If snapshot cnt < MIN_PIXELS (including 0), go to REPORT with FOUND=0.
    - Otherwise go to DIVIDE.
  - DIVIDE:
    - Two parallel restoring dividers: sum_x/cnt and sum_y/cnt, 29 iterations, one quotient bit per cycle.
    - Quotients are truncated to 10 bits (always < 640 and < 480 respectively).
    - Go to REPORT.
  - REPORT:
    - Load PIXELS, FOUND and BBOX.
    - Load X_POS/Y_POS only if FOUND; otherwise they hold their previous values.
    - Pulse VALID; go to IDLE.
- Close while in DIVIDE or REPORT:
  - Set OVERRUN.
  - Clear the accumulators anyway.
  - Discard that frame's snapshot.
- ENABLE low:
  - Accumulators held at their cleared values.
  - Closes ignored; no VALID.
  - An in-flight divide completes normally.
- Sums cannot overflow: 639 × 307200 < 2^29.

## Timing
- All outputs reset to 0, except BBOX, which resets to {1023, 0, 1023, 0}.
- RST mid-divide aborts the division. The FSM returns to IDLE and accumulators clear.
- Latency from the close cycle C:
  - FOUND path: VALID at C+31 (1 snapshot cycle, 29 divide cycles, 1 report cycle).
  - Below MIN_PIXELS: VALID at C+2.
- Outputs are stable from the VALID cycle until the next VALID.
- VGA blanking (≥ 45 lines) far exceeds 31 cycles, so OVERRUN indicates abnormal counters.

## Configuration
- `BALL_TRACKER_BBOX_EN` defined:
  - Bounding box logic is built.
  - BBOX is driven as specified.
- Not defined:
  - Min/max registers are omitted.
  - BBOX is tied to its reset value {1023, 0, 1023, 0}.
  - All other behaviour is identical.

## Test plan
- Single hit at H_CNT=144+100, V_CNT=35+50, then V wrap → VALID at C+31 with X_POS=100, Y_POS=50, PIXELS=1.
  - Run this with MIN_PIXELS=1.
- 10×10 block of hits, x 200..209, y 300..309 → X_POS=204, Y_POS=304, PIXELS=100, FOUND=1, BBOX={200, 209, 300, 309}.
- 5 hits with MIN_PIXELS=16 → VALID at C+2, FOUND=0, PIXELS=5, X_POS/Y_POS unchanged from the previous frame.
- Second V wrap injected 10 cycles after a close → OVERRUN=1; the first frame's result still reports correctly at C+31.
- ENABLE=0 through a full frame of hits → no VALID; after ENABLE=1, the next frame reports only hits seen after re-enable.
- RST asserted at C+15 → no VALID, all outputs at reset values, and the next full frame reports correctly.
